// File: rtl/cpu_pkg.sv
// Shared CPU types: machine/instruction widths and the fetch-entry record
// carried from instruction fetch to decode.
package cpu_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  localparam int FE_W = $bits(fetch_entry_t);

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry circular buffer of fetch entries with single-cycle flush.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_push,
  input  logic [FE_W-1:0] i_entry,
  input  logic            i_pop,
  output logic [FE_W-1:0] o_head,
  output logic [CW-1:0]   o_count,
  output logic            o_empty
);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];

  // Flush wins over both ports; a push into a full buffer is only legal alongside a pop.
  assign w_pop  = i_pop & ~o_empty & ~i_flush;
  assign w_push = i_push & ~i_flush & ((r_count != FULL) | w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= fetch_entry_t'(i_entry);
  end
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: PC, credit-based request issue and decode queue.
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [ILEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc
);
  localparam int            CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN-1:0] r_pc;
  logic            r_inflight;
  logic [XLEN-1:0] r_inflight_pc;

  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_used;
  logic            w_empty;
  fetch_entry_t    w_head;
  fetch_entry_t    w_out;
  logic            w_out_valid;
  logic            w_push;
  logic            w_pop;
  logic [FE_W-1:0] w_resp;

  assign w_resp = {imem_rdata, r_inflight_pc};

  // Every outstanding request already owns a queue slot, so the buffer cannot overflow.
  assign w_used    = w_count + CW'(r_inflight);
  assign imem_req  = reset & ~redirect_valid & (w_used < FULL);
  assign imem_addr = r_pc;

`ifdef FETCH_BYPASS_EN
  logic w_bypass;
  assign w_bypass    = w_empty & r_inflight;
  assign w_out       = w_bypass ? fetch_entry_t'(w_resp) : w_head;
  assign w_out_valid = ~w_empty | r_inflight;
  assign w_push      = r_inflight & ~(w_bypass & dec_ready);
  assign w_pop       = ~w_empty & dec_ready;
`else
  assign w_out       = w_head;
  assign w_out_valid = ~w_empty;
  assign w_push      = r_inflight;
  assign w_pop       = ~w_empty & dec_ready;
`endif

  // A redirecting cycle hands nothing to decode; the entries behind it are wrong-path.
  assign dec_valid = w_out_valid & ~redirect_valid;
  assign dec_instr = dec_valid ? w_out.instr : '0;
  assign dec_pc    = dec_valid ? w_out.pc    : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (redirect_valid) begin
      r_pc       <= align_word(redirect_addr);
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= imem_req;
      if (imem_req) begin
        r_inflight_pc <= r_pc;
        r_pc          <= r_pc + 32'd4;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_entry (w_resp),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );
endmodule
